// File: rtl/crypt_pkg.sv
// Shared types and helpers for the byte-permutation cipher round controller.
package crypt_pkg;

  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrl_state_t;

  // Decrypt walks the logical step indices backwards so involutive stages undo encryption.
  function automatic int step_index(input int j, input logic decrypt, input int n);
    return decrypt ? (n - 1 - j) : j;
  endfunction

endpackage

// File: rtl/crypt_keybit_sel.sv
// Picks the two key bits for a logical step index, wrapping around the key width.
module crypt_keybit_sel
  import crypt_pkg::*;
#(
  parameter int KEY_W = 32
) (
  input  logic [KEY_W-1:0] key,
  input  logic [31:0]      step_idx,
  output logic [1:0]       k
);

  logic [31:0]      base;
  logic [KEY_W-1:0] shifted;

  // Reducing mod KEY_W/2 before doubling keeps the bit offset in range for any index.
  assign base    = (step_idx % 32'(KEY_W / 2)) << 1;
  assign shifted = key >> base;
  assign k       = shifted[1:0];

endmodule

// File: rtl/crypt_round_ctrl.sv
// Round sequencer: owns the cipher state and time-shares the stage bus,
// enabling exactly one stage per cycle while a block is running.
module crypt_round_ctrl
  import crypt_pkg::*;
#(
  parameter int NUM_ROUNDS = 4,
  parameter int NUM_STAGES = 3,
  parameter int KEY_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLOCK_W-1:0]    in_data,
  input  logic [KEY_W-1:0]      in_key,
  input  logic                  in_decrypt,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_W-1:0]    out_data,
  output logic [NUM_STAGES-1:0] st_en,
  output logic [1:0]            st_k,
  output logic                  st_mode,
  output logic [BLOCK_W-1:0]    st_dout,
  input  logic [BLOCK_W-1:0]    st_din,
  output logic                  busy
);

  localparam int N     = NUM_ROUNDS * NUM_STAGES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  ctrl_state_t        state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               mode_q, mode_d;
  logic               in_ready_q, in_ready_d;
  logic [31:0]        p_idx;
  logic [31:0]        stage_sel;
  logic [1:0]         sel_k;
  logic               accept;

  assign p_idx     = 32'(step_index(int'(step_q), mode_q, N));
  assign stage_sel = p_idx % 32'(NUM_STAGES);

  crypt_keybit_sel #(.KEY_W(KEY_W)) u_keybit_sel (
    .key      (key_q),
    .step_idx (p_idx),
    .k        (sel_k)
  );

  assign accept    = (state_q == IDLE) && in_ready_q && in_valid && !abort;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign st_dout   = data_q;
  assign st_mode   = mode_q;
  assign busy      = (state_q != IDLE);
  assign st_k      = (state_q == RUN) ? sel_k : 2'b00;

  // Only one tri-state stage may drive the shared bus, and none outside RUN.
  always_comb begin
    st_en = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      st_en[i] = (state_q == RUN) && (stage_sel == 32'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    data_d  = data_q;
    key_d   = key_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          data_d  = in_data;
          key_d   = in_key;
          mode_d  = in_decrypt;
          step_d  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          step_d  = '0;
        end else begin
          data_d = st_din;
          if (step_q == LAST_STEP) begin
            step_d  = '0;
            state_d = DONE;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: low through reset, high from the first edge that lands in IDLE.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      data_q     <= '0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      data_q     <= data_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
